// File: rtl/uart_ctrl.sv
// rtl/uart_ctrl.sv - Parametrised full-duplex UART with Tx/Rx FIFOs and sticky error flags.
// Status flags of the FIFO are registered; the head is first-word fall-through.
module uart_ctrl_fifo #(
    parameter int W   = 8,
    parameter int LOG = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam logic [LOG:0] DEPTH = (LOG+1)'(1 << LOG);

    logic [W-1:0]   mem_q [1 << LOG];
    logic [LOG-1:0] wr_q, rd_q;
    logic [LOG:0]   cnt_q, cnt_d;
    logic           full_q, empty_q;
    logic           do_push, do_pop;

    // full is the registered value, so a push while full is dropped even alongside a pop
    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;

    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop)
            cnt_d = cnt_q + 1'b1;
        else if (do_pop && !do_push)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == DEPTH);
            empty_q <= (cnt_d == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    assign head_o  = empty_q ? '0 : mem_q[rd_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
endmodule

module uart_ctrl #(
    parameter int BAUDRATE  = 25000000,
    parameter int CLOCKRATE = 100000000,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 1,
    parameter int STOP_BITS = 1,
    parameter int FIFO_LOG  = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 send_flag,
    input  logic [DATA_BITS-1:0] send_data,
    input  logic                 recv_flag,
    output logic [DATA_BITS-1:0] recv_data,
    output logic                 sendable,
    output logic                 receivable,
    output logic                 tx_busy,
    input  logic                 err_clear,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 Tx,
    input  logic                 Rx
);
    localparam int INTERVAL = CLOCKRATE / BAUDRATE;
    localparam int CW = $clog2(INTERVAL);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(INTERVAL - 1);
    localparam logic [CW-1:0] CNT_MID   = CW'(INTERVAL / 2);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic          PAR_ODD   = (PARITY == 2);

    localparam logic [2:0] TX_IDLE = 3'd0, TX_START = 3'd1, TX_DATA = 3'd2,
                           TX_PARITY = 3'd3, TX_STOP = 3'd4;
    localparam logic [2:0] RX_WAIT_HIGH = 3'd0, RX_IDLE = 3'd1, RX_START = 3'd2,
                           RX_DATA = 3'd3, RX_PARITY = 3'd4, RX_STOP = 3'd5;

    logic                 tx_pop, tx_full, tx_empty, tx_load, tx_end;
    logic [DATA_BITS-1:0] tx_head;
    logic [2:0]           tx_state_q, tx_state_d;
    logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [BW-1:0]        tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d, tx_q, tx_d;

    logic                 rx_meta_q, rxs_q, rx_push, rx_full, rx_empty, rx_sample;
    logic [2:0]           rx_state_q, rx_state_d;
    logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
    logic [BW-1:0]        rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_perr_q, rx_perr_d, rx_ferr_q, rx_ferr_d, rx_done_q, rx_done_d;
    logic                 par_err_q, par_err_d, frm_err_q, frm_err_d, ovr_q, ovr_d;

    uart_ctrl_fifo #(.W(DATA_BITS), .LOG(FIFO_LOG)) u_tx_fifo (
        .clk_i(CLK), .rst_i(RST), .push_i(send_flag), .data_i(send_data),
        .pop_i(tx_pop), .head_o(tx_head), .full_o(tx_full), .empty_o(tx_empty)
    );

    uart_ctrl_fifo #(.W(DATA_BITS), .LOG(FIFO_LOG)) u_rx_fifo (
        .clk_i(CLK), .rst_i(RST), .push_i(rx_push), .data_i(rx_shift_q),
        .pop_i(recv_flag), .head_o(recv_data), .full_o(rx_full), .empty_o(rx_empty)
    );

    assign tx_end = (tx_cnt_q == CNT_LAST);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_d       = tx_q;
        tx_pop     = 1'b0;
        tx_load    = 1'b0;
        if (tx_state_q != TX_IDLE)
            tx_cnt_d = tx_end ? '0 : tx_cnt_q + 1'b1;
        case (tx_state_q)
            TX_IDLE: tx_load = 1'b1;
            TX_START: if (tx_end) begin
                tx_state_d = TX_DATA;
                tx_bit_d   = '0;
                tx_d       = tx_shift_q[0];
            end
            TX_DATA: if (tx_end) begin
                tx_shift_d = tx_shift_q >> 1;
                if (tx_bit_q == DATA_LAST) begin
                    tx_bit_d   = '0;
                    tx_state_d = (PARITY != 0) ? TX_PARITY : TX_STOP;
                    tx_d       = (PARITY != 0) ? tx_par_q : 1'b1;
                end else begin
                    tx_bit_d = tx_bit_q + 1'b1;
                    tx_d     = tx_shift_q[1];
                end
            end
            TX_PARITY: if (tx_end) begin
                tx_state_d = TX_STOP;
                tx_d       = 1'b1;
            end
            TX_STOP: if (tx_end) begin
                if (tx_bit_q == STOP_LAST) begin
                    tx_state_d = TX_IDLE;
                    tx_bit_d   = '0;
                    tx_load    = 1'b1;
                end else begin
                    tx_bit_d = tx_bit_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        // reloading at the end of the last stop bit gives back-to-back frames
        if (tx_load && !tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_head;
            tx_par_d   = (^tx_head) ^ PAR_ODD;
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
            tx_state_d = TX_START;
            tx_d       = 1'b0;
        end
    end

    assign rx_sample = (rx_cnt_q == CNT_MID);

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_perr_d  = rx_perr_q;
        rx_ferr_d  = rx_ferr_q;
        rx_done_d  = 1'b0;
        if (rx_state_q != RX_WAIT_HIGH && rx_state_q != RX_IDLE)
            rx_cnt_d = (rx_cnt_q == CNT_LAST) ? '0 : rx_cnt_q + 1'b1;
        case (rx_state_q)
            RX_WAIT_HIGH: if (rxs_q) rx_state_d = RX_IDLE;
            RX_IDLE: if (!rxs_q) begin
                rx_state_d = RX_START;
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_perr_d  = 1'b0;
                rx_ferr_d  = 1'b0;
            end
            RX_START: if (rx_sample) rx_state_d = rxs_q ? RX_IDLE : RX_DATA;
            RX_DATA: if (rx_sample) begin
                rx_shift_d = {rxs_q, rx_shift_q[DATA_BITS-1:1]};
                if (rx_bit_q == DATA_LAST) begin
                    rx_bit_d   = '0;
                    rx_state_d = (PARITY != 0) ? RX_PARITY : RX_STOP;
                end else begin
                    rx_bit_d = rx_bit_q + 1'b1;
                end
            end
            RX_PARITY: if (rx_sample) begin
                rx_perr_d  = rxs_q ^ (^rx_shift_q) ^ PAR_ODD;
                rx_state_d = RX_STOP;
            end
            RX_STOP: if (rx_sample) begin
                if (!rxs_q) rx_ferr_d = 1'b1;
                if (rx_bit_q == STOP_LAST) begin
                    rx_done_d  = 1'b1;
                    rx_state_d = rx_ferr_d ? RX_WAIT_HIGH : RX_IDLE;
                end else begin
                    rx_bit_d = rx_bit_q + 1'b1;
                end
            end
            default: rx_state_d = RX_WAIT_HIGH;
        endcase
    end

    // frame verdict is acted on the cycle after the final stop sample
    assign rx_push   = rx_done_q && !rx_ferr_q && !rx_perr_q;
    assign par_err_d = (rx_done_q && rx_perr_q) || (par_err_q && !err_clear);
    assign frm_err_d = (rx_done_q && rx_ferr_q) || (frm_err_q && !err_clear);
    assign ovr_d     = (rx_push && rx_full) || (ovr_q && !err_clear);

    always_ff @(posedge CLK) begin
        if (RST) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rx_state_q <= RX_WAIT_HIGH;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_done_q  <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
            rx_meta_q  <= Rx;
            rxs_q      <= rx_meta_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_perr_q  <= rx_perr_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_done_q  <= rx_done_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
            ovr_q      <= ovr_d;
        end
    end

    assign Tx         = tx_q;
    assign tx_busy    = (tx_state_q != TX_IDLE);
    assign sendable   = !tx_full;
    assign receivable = !rx_empty;
    assign parity_err = par_err_q;
    assign frame_err  = frm_err_q;
    assign overrun    = ovr_q;
endmodule
